// File: rtl/pack_buffer.sv
// Ping-pong lane gatherer: packs a stream of BITi-bit words into SIZE-lane vectors
// with valid/ready on both sides and early termination via in_last.
module pack_buffer #(
    parameter int SIZE = 8,
    parameter int BITi = 16,
    parameter int BITo = SIZE * BITi,
    parameter int BITn = $clog2(SIZE + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITi-1:0] in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITo-1:0] out_data,
    output logic [BITn-1:0] out_cnt,
    output logic            out_last
);

    localparam int LW = (SIZE > 1) ? $clog2(SIZE) : 1;

    if (BITo != SIZE * BITi || SIZE < 2) begin : g_bad_params
        $error("pack_buffer: BITo must equal SIZE*BITi and SIZE must be at least 2");
    end

    logic [1:0][SIZE-1:0][BITi-1:0] mem_q, mem_d;
    logic [1:0][BITn-1:0]           cnt_q, cnt_d;
    logic [1:0]                     full_q, full_d;
    logic [1:0]                     last_q, last_d;
    logic                           wr_bank_q, wr_bank_d;
    logic                           rd_bank_q, rd_bank_d;
    logic                           rdy_en_q, rdy_en_d;

    logic                           in_acc;
    logic                           out_acc;
    logic [BITn-1:0]                cnt_inc;
    logic [LW-1:0]                  lane;

    // rdy_en_q keeps in_ready low through reset and up to the first clock edge
    assign in_ready  = rdy_en_q & ~full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign in_acc    = in_valid & in_ready;
    assign out_acc   = out_valid & out_ready;
    assign cnt_inc   = cnt_q[wr_bank_q] + BITn'(1);
    assign lane      = cnt_q[wr_bank_q][LW-1:0];

    assign out_data  = out_valid ? mem_q[rd_bank_q] : '0;
    assign out_cnt   = out_valid ? cnt_q[rd_bank_q] : '0;
    assign out_last  = out_valid ? last_q[rd_bank_q] : 1'b0;

    always_comb begin
        mem_d     = mem_q;
        cnt_d     = cnt_q;
        full_d    = full_q;
        last_d    = last_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        rdy_en_d  = 1'b1;
        if (clear) begin
            mem_d     = '0;
            cnt_d     = '0;
            full_d    = '0;
            last_d    = '0;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
        end else begin
            // in_acc needs a free bank and out_acc a full one, so they never touch the same bank
            if (out_acc) begin
                full_d[rd_bank_q] = 1'b0;
                cnt_d[rd_bank_q]  = '0;
                last_d[rd_bank_q] = 1'b0;
                mem_d[rd_bank_q]  = '0;
                rd_bank_d         = ~rd_bank_q;
            end
            if (in_acc) begin
                mem_d[wr_bank_q][lane] = in_data;
                cnt_d[wr_bank_q]       = cnt_inc;
                if (cnt_inc == BITn'(SIZE) || in_last) begin
                    full_d[wr_bank_q] = 1'b1;
                    last_d[wr_bank_q] = in_last;
                    wr_bank_d         = ~wr_bank_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q     <= '0;
            cnt_q     <= '0;
            full_q    <= '0;
            last_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            last_q    <= last_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            rdy_en_q  <= rdy_en_d;
        end
    end

endmodule
